dmem_port: RTL

DMEM_PORT -- requirements
Module: dmem_port

---
 rtl/dmem_port.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_port.sv
// dmem_port: single-port byte-addressable data memory behind a valid/ready
// request interface with a one-cycle response strobe.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  access request (in)
//   req_ready  block can accept a request (out, high only in IDLE)
//   wren       1 = store, 0 = load
//   addr       byte address, ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH
//   data       store data, right-justified
//   dataSize   00 byte, 01 half, 10/11 word
//   isSigned   sign-extend (1) or zero-extend (0) load results
//   rsp_valid  one-cycle response strobe (registered)
//   q          load result, 0 for stores; held until the next response
//   err        misaligned-access flag, valid with rsp_valid
//   fsm_state  current FSM state (debug)
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready
// and rst is low; all request fields are sampled on that edge. req_valid while
// req_ready is low is ignored. The response is a single-cycle rsp_valid pulse
// with q/err, issued 1+DELAY edges after the accept edge.
//
// Configuration macro DMEM_PORT_MISALIGN_TRAP_EN:
//   defined   - misaligned half/word accesses report err=1, stores are
//               dropped and loads return 0.
//   undefined - low address bits are forced to the access alignment and
//               err is always 0.

module dmem_port #(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DELAY      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BIT_WIDTH-1:0]  data,
    input  logic [1:0]            dataSize,
    input  logic                  isSigned,
    output logic                  rsp_valid,
    output logic [BIT_WIDTH-1:0]  q,
    output logic                  err,
    output logic [1:0]            fsm_state
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam logic [2:0] WAIT_LAST = (DELAY > 0) ? 3'(DELAY - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]            wait_cnt;
    logic [BIT_WIDTH-1:0]  mem [DEPTH];
    logic                  accept;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic [3:0]            lane_en;
    logic [BIT_WIDTH-1:0]  wr_word;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  wren_r;
    logic [1:0]            size_r;
    logic                  signed_r;
    logic                  drop_r;

    logic [BIT_WIDTH-1:0]  rd_word;
    logic [BIT_WIDTH-1:0]  rd_shift;
    logic [BIT_WIDTH-1:0]  load_val;

    assign req_ready = (state == IDLE);
    assign fsm_state = state;
    // Reset wins over a simultaneous request.
    assign accept    = req_valid && req_ready && !rst;

`ifdef DMEM_PORT_MISALIGN_TRAP_EN
    assign drop     = ((dataSize == 2'b01) && addr[0]) ||
                      (dataSize[1] && (addr[1:0] != 2'b00));
    assign addr_eff = addr;
`else
    assign drop = 1'b0;
    always_comb begin
        addr_eff = addr;
        if (dataSize == 2'b01) begin
            addr_eff[0] = 1'b0;
        end else if (dataSize[1]) begin
            addr_eff[1:0] = 2'b00;
        end
    end
`endif

    // Byte enables and lane-replicated store data: the addressed lanes pick
    // their bytes straight out of the replicated word.
    always_comb begin
        lane_en = 4'b1111;
        wr_word = data;
        case (dataSize)
            2'b00: begin
                lane_en = 4'b0001 << addr_eff[1:0];
                wr_word = {4{data[7:0]}};
            end
            2'b01: begin
                lane_en = addr_eff[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{data[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wr_word = data;
            end
        endcase
    end

    // Stores commit on the accept edge; memory is never reset.
    always_ff @(posedge clk) begin
        if (accept && wren && !drop) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[addr_eff[ADDR_WIDTH-1:2]][8*k +: 8] <= wr_word[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_r   <= addr_eff;
            wren_r   <= wren;
            size_r   <= dataSize;
            signed_r <= isSigned;
            drop_r   <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = (DELAY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 3'd0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 3'd1;
        end else begin
            wait_cnt <= 3'd0;
        end
    end

    // Load path: bring the addressed byte/half down to bit 0, then extend.
    assign rd_word  = mem[addr_r[ADDR_WIDTH-1:2]];
    assign rd_shift = rd_word >> {addr_r[1:0], 3'b000};

    always_comb begin
        load_val = rd_shift;
        case (size_r)
            2'b00:   load_val = {{24{signed_r & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = {{16{signed_r & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
    end

    // Response registers are loaded while in RESP, so the strobe appears the
    // cycle after RESP, alongside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            q         <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= (state == RESP);
            if (state == RESP) begin
                q   <= (wren_r || drop_r) ? '0 : load_val;
                err <= drop_r;
            end
        end
    end

endmodule
